// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode constants carried on the 3-bit control bus
//   - FSM state encoding for alu_mc
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for an operation
    S_MUL  = 2'd1,  // shift-add multiply in progress
    S_DONE = 2'd2   // holding a result for the consumer
  } alu_state_t;

endpackage

// File: rtl/alu_bit.sv
// alu_bit: one-bit ALU slice.
//   a, b   : operand bits
//   binv   : invert b before the adder (subtract)
//   cin    : carry in from the next-lower slice
//   y_and  : a & b
//   y_or   : a | b
//   sum    : full-adder sum of a, b^binv, cin
//   cout   : full-adder carry out
module alu_bit (
  input  logic a,
  input  logic b,
  input  logic binv,
  input  logic cin,
  output logic y_and,
  output logic y_or,
  output logic sum,
  output logic cout
);

  logic b_eff;

  // Logic ops use the raw b; only the adder sees the inverted operand.
  assign b_eff = b ^ binv;
  assign y_and = a & b;
  assign y_or  = a | b;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with valid/ready on both sides.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operation request / block can accept this cycle
//   a, b, control       : operands and opcode (see alu_pkg)
//   out_valid/out_ready : result presented / consumer takes it
//   result, zero        : registered result and result==0
//   carry               : adder carry-out, or MUL upper-half non-zero
//   overflow            : signed overflow for ADD/SUB
// Single-cycle ops complete on the accept edge; MUL runs WIDTH shift-add
// steps through the same bit-slice chain used by ADD/SUB.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  alu_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;   // latched multiplicand
  logic [WIDTH-1:0] acc;     // upper product half
  logic [WIDTH-1:0] mplier;  // multiplier, shifted out as product low half fills in

  logic             accept;
  logic [WIDTH-1:0] chain_a, chain_b;
  logic             chain_inv;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] and_v, or_v, sum_v;

  logic [WIDTH-1:0] b_eff;
  logic             add_ovf;
  logic [WIDTH-1:0] op_result;
  logic             op_carry, op_ovf;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // The chain is shared: during MUL it adds the multiplicand into the upper
  // half when the current multiplier bit is set, otherwise it serves a/b.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    if (state == S_MUL) begin
      chain_a   = acc;
      chain_b   = mplier[0] ? mcand : '0;
      chain_inv = 1'b0;
    end else begin
      chain_a   = a;
      chain_b   = b;
      chain_inv = (control == OP_SUB) || (control == OP_SLT);
    end
  end

  assign c[0] = chain_inv;  // carry-in of 1 completes the two's complement

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit u_bit (
      .a     (chain_a[i]),
      .b     (chain_b[i]),
      .binv  (chain_inv),
      .cin   (c[i]),
      .y_and (and_v[i]),
      .y_or  (or_v[i]),
      .sum   (sum_v[i]),
      .cout  (c[i+1])
    );
  end

  assign b_eff   = chain_inv ? ~b : b;
  assign add_ovf = (a[MSB] == b_eff[MSB]) && (sum_v[MSB] != a[MSB]);

  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    op_ovf    = 1'b0;
    case (control)
      OP_AND: op_result = and_v;
      OP_OR:  op_result = or_v;
      OP_ADD, OP_SUB: begin
        op_result = sum_v;
        op_carry  = c[WIDTH];
        op_ovf    = add_ovf;
      end
      // Signed less-than: sign of a-b corrected by overflow.
      OP_SLT: op_result = {{(WIDTH-1){1'b0}}, sum_v[MSB] ^ add_ovf};
      default: ;  // illegal opcodes produce 0 with clear flags
    endcase
  end

  // One shift-add step: {carry, sum} shifts right into the product pair.
  assign step_hi = {c[WIDTH], sum_v[WIDTH-1:1]};
  assign step_lo = {sum_v[0], mplier[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the multiply datapath registers are reset too, so a fresh block never carries X into a result.
      state    <= S_IDLE;
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      result   <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_MUL: begin
          acc    <= step_hi;
          mplier <= step_lo;
          count  <= count + CW'(1);
          if (count == LAST_STEP) begin
            result   <= step_lo;
            zero     <= (step_lo == '0);
            carry    <= (step_hi != '0);
            overflow <= 1'b0;
            state    <= S_DONE;
          end
        end
        default: begin  // S_IDLE and S_DONE
          if (accept) begin
            if (control == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              count  <= '0;
              state  <= S_MUL;
            end else begin
              result   <= op_result;
              zero     <= (op_result == '0);
              carry    <= op_carry;
              overflow <= op_ovf;
              state    <= S_DONE;
            end
          end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
